uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver. It is the host->board counterpart of the existing UART
//  transmitter on the 12 MHz system clock. It deserialises bytes from the
//  FTDI RX pin and holds each one in a single-entry output buffer until the
//  consumer reads it, for example a command decoder that triggers frame dumps.
//  Framing errors and overruns are flagged; glitches are rejected.
// PARAMETERS
//  CLK_HZ   12000000  system clock frequency in Hz
//  BAUD     115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated (104 at defaults)
//  (CLKS_PER_BIT < 4 is illegal: $error at elaboration)
// PORTS
//  sys_clk_i     in   1  system clock; all logic on the rising edge
//  sys_rst_n_i   in   1  asynchronous reset, active low
//  uart_rx_i     in   1  serial line, idle high, asynchronous to sys_clk_i
//  uart_dat_o    out  8  received byte; valid while uart_valid_o=1
//  uart_valid_o  out  1  buffer holds an unread byte
//  uart_rd_i     in   1  consumer pop; ignored when uart_valid_o=0
//  uart_ovr_o    out  1  sticky: a complete byte was dropped because the buffer was full
//  uart_ferr_o   out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset values: uart_dat_o=0, uart_valid_o=0, uart_ovr_o=0, uart_ferr_o=0.
//   The synchroniser resets to 1. The FSM resets to WAIT_IDLE.
//  Input path: 2-flop synchroniser; the FSM uses only the synchronised value rxs.
//  Bit counter: down-counter, width $clog2(CLKS_PER_BIT). Expiry occurs at count 0.
//  FSM:
//   WAIT_IDLE: when rxs=1 for 1 cycle -> IDLE. This prevents a start triggering mid-frame after reset or error.
//   IDLE: when rxs=0 -> START, counter=CLKS_PER_BIT/2-1.
//   START: at expiry, rxs=0 -> DATA, counter=CLKS_PER_BIT-1, bit index=0;
//    rxs=1 -> IDLE (glitch; no flags raised).
//   DATA: at each expiry, shift rxs into bit[index] (LSB first) and reload the counter.
//    After bit 7 -> STOP.
//   STOP: at expiry, rxs=1 -> frame good, go to IDLE;
//    rxs=0 -> uart_ferr_o=1 for 1 cycle, byte discarded, go to WAIT_IDLE. A break is reported as one ferr.
//  Frame-good commit, on the cycle after the stop sample:
//   - buffer empty, or uart_rd_i=1 that cycle: uart_dat_o<=byte, uart_valid_o<=1.
//   - else: byte dropped, uart_dat_o unchanged, uart_ovr_o<=1.
//  Read: uart_rd_i=1 with uart_valid_o=1 -> uart_valid_o<=0 next cycle, unless a commit occurs in the same cycle.
//   Any uart_rd_i=1 clears uart_ovr_o, unless an overrun occurs in the same cycle; in that case ovr is set.
//  Latency: uart_valid_o rises 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT+2 cycles (+-1) after the line falls.
//   At defaults this is 992 cycles.
//  Mid-operation reset: all state is abandoned. No partial byte is ever committed.
//  Frames may be back-to-back: IDLE is re-entered half a bit before the line stop bit ends.
// TESTING
//  1. Send 0xA5 at 104 clk/bit. Expect uart_dat_o=0xA5, uart_valid_o=1 at 992+-2 cycles,
//     ovr=0, ferr=0. Pulse rd: valid=0 next cycle.
//  2. Send 0x11 then 0x22 back-to-back with no rd. Expect dat=0x11, valid=1, ovr=1.
//     Then rd: valid=0, ovr=0.
//  3. Send 0x5A with the stop bit forced low, then line high, then 0x3C. Expect one ferr pulse,
//     no valid for 0x5A, then dat=0x3C, valid=1.
//  4. Hold the line low for 20 cycles, then high. Expect no valid, ferr or ovr. The next byte 0x7E is received correctly.
//  5. Drive the line low, then assert reset mid-frame. Release reset while the line is still low for 300 cycles,
//     then send 0x55. Expect no spurious byte, then dat=0x55.
//  6. Leave 0x01 buffered. Pulse rd on the exact commit cycle of 0x02.
//     Expect dat=0x02, valid=1, ovr=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a single-entry output buffer, overrun and framing-error flags
// Ports: sys_clk_i clock, sys_rst_n_i async active-low reset, uart_rx_i serial line (idle high),
//        uart_dat_o/uart_valid_o buffered byte, uart_rd_i pop, uart_ovr_o sticky overrun,
//        uart_ferr_o one-cycle framing-error pulse
module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_rd_i,
  output logic       uart_ovr_o,
  output logic       uart_ferr_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate
  logic [1:0]    r_sync;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_dat;
  logic          r_good;
  logic          r_valid;
  logic          r_ovr;
  logic          r_ferr;
  logic          w_rxs;
  logic          w_exp;
  logic          w_commit;
  logic          w_drop;
  assign w_rxs    = r_sync[1];
  assign w_exp    = r_cnt == '0;
  assign w_commit = r_good & (~r_valid | uart_rd_i);
  assign w_drop   = r_good & r_valid & ~uart_rd_i;
  // After reset the counter starts at 2 so WAIT_IDLE ignores the synchroniser's
  // reset value and only trusts a high level that was really sampled from the line.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i)
    if (!sys_rst_n_i) begin
      r_sync  <= 2'b11;
      r_state <= S_WAIT_IDLE;
      r_cnt   <= CW'(2);
      r_idx   <= '0;
      r_shift <= '0;
      r_good  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], uart_rx_i};
      r_good <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_WAIT_IDLE:
          if (!w_exp) r_cnt <= r_cnt - 1'b1;
          else if (w_rxs) r_state <= S_IDLE;
        S_IDLE:
          if (!w_rxs) begin
            r_state <= S_START;
            r_cnt   <= HALF;
          end
        S_START:
          if (!w_exp) r_cnt <= r_cnt - 1'b1;
          else if (w_rxs) r_state <= S_IDLE;
          else begin
            r_state <= S_DATA;
            r_cnt   <= FULL;
            r_idx   <= '0;
          end
        S_DATA:
          if (!w_exp) r_cnt <= r_cnt - 1'b1;
          else begin
            r_shift[r_idx] <= w_rxs;
            r_cnt          <= FULL;
            r_idx          <= r_idx + 1'b1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end
        S_STOP:
          if (!w_exp) r_cnt <= r_cnt - 1'b1;
          else begin
            r_good  <= w_rxs;
            r_ferr  <= ~w_rxs;
            r_state <= w_rxs ? S_IDLE : S_WAIT_IDLE;
          end
        default: r_state <= S_WAIT_IDLE;
      endcase
    end
  // A commit in the same cycle as a read wins; an overrun in the same cycle as a read wins.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i)
    if (!sys_rst_n_i) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_commit) r_dat <= r_shift;
      r_valid <= w_commit | (r_valid & ~uart_rd_i);
      r_ovr   <= w_drop | (r_ovr & ~uart_rd_i);
    end
  assign uart_dat_o   = r_dat;
  assign uart_valid_o = r_valid;
  assign uart_ovr_o   = r_ovr;
  assign uart_ferr_o  = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-scheduled model of the receiver's buffer
module tb_uart_rx;
  localparam int CPB = 104;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 2;
  typedef struct {
    int         due;
    logic [7:0] b;
    bit         good;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ovr;
  logic       ferr;
  int         cyc = 0;
  int         vecs = 0;
  int         errs = 0;
  int         ferr_seen = 0;
  logic       rd_q = 1'b0;
  ev_t        q[$];
  ev_t        e;
  logic [7:0] m_dat = '0;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  uart_rx dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .uart_rx_i   (rx),
    .uart_dat_o  (dat),
    .uart_valid_o(valid),
    .uart_rd_i   (rd),
    .uart_ovr_o  (ovr),
    .uart_ferr_o (ferr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= rd;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  // Frames mature at fixed edges after the line falls; the buffer rules are applied to
  // whatever matures on the edge just taken, using the read strobe seen on that edge.
  always @(negedge clk) begin : model
    automatic logic [7:0] nd = m_dat;
    automatic logic       nv = m_valid;
    automatic logic       no = m_ovr;
    automatic logic       nf = 1'b0;
    automatic bit         good = 1'b0;
    automatic logic [7:0] gb = '0;
    if (!rst_n) begin
      nd = '0;
      nv = 1'b0;
      no = 1'b0;
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.good) begin
          good = 1'b1;
          gb   = e.b;
        end else nf = 1'b1;
      end
      if (good && m_valid && !rd_q) no = 1'b1;
      else if (rd_q) no = 1'b0;
      if (good && (!m_valid || rd_q)) begin
        nd = gb;
        nv = 1'b1;
      end else if (rd_q) nv = 1'b0;
    end
    m_dat   <= nd;
    m_valid <= nv;
    m_ovr   <= no;
    if (ferr) ferr_seen <= ferr_seen + 1;
    chk("model.dat", {24'b0, dat}, {24'b0, nd});
    chk("model.valid", {31'b0, valid}, {31'b0, nv});
    chk("model.ovr", {31'b0, ovr}, {31'b0, no});
    chk("model.ferr", {31'b0, ferr}, {31'b0, nf});
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    q.push_back(ev_t'{due: cyc + (stop ? LAT : LAT - 1), b: b, good: stop});
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop;
    cycles(CPB);
    rx = 1'b1;
  endtask
  task automatic rd_pulse();
    rd = 1'b1;
    cycles(1);
    rd = 1'b0;
  endtask
  task automatic expect_buf(input string tag, input logic [7:0] d, input logic v, input logic o);
    @(negedge clk);
    chk({tag, ".dat"}, {24'b0, dat}, {24'b0, d});
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, ".ovr"}, {31'b0, ovr}, {31'b0, o});
    @(posedge clk);
    #1;
  endtask
  task automatic pin(input logic [7:0] b);
    cycles(991);
    @(negedge clk);
    chk("pin.pre_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk("pin.valid", {31'b0, valid}, 32'd1);
    chk("pin.dat", {24'b0, dat}, {24'b0, b});
  endtask
  initial begin
    int base;
    cycles(3);
    expect_buf("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.ferr", {31'b0, ferr}, 32'd0);
    rst_n = 1'b1;
    cycles(20);
    fork
      send(8'hA5, 1'b1);
      pin(8'hA5);
    join
    expect_buf("t1", 8'hA5, 1'b1, 1'b0);
    rd_pulse();
    expect_buf("t1_rd", 8'hA5, 1'b0, 1'b0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    expect_buf("t2", 8'h11, 1'b1, 1'b1);
    rd_pulse();
    expect_buf("t2_rd", 8'h11, 1'b0, 1'b0);
    base = ferr_seen;
    send(8'h5A, 1'b0);
    cycles(30);
    expect_buf("t3_bad", 8'h11, 1'b0, 1'b0);
    send(8'h3C, 1'b1);
    expect_buf("t3", 8'h3C, 1'b1, 1'b0);
    chk("t3.ferr_count", ferr_seen - base, 32'd1);
    rd_pulse();
    base = ferr_seen;
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(200);
    expect_buf("t4_glitch", 8'h3C, 1'b0, 1'b0);
    send(8'h7E, 1'b1);
    expect_buf("t4", 8'h7E, 1'b1, 1'b0);
    chk("t4.ferr_count", ferr_seen - base, 32'd0);
    rd_pulse();
    rx = 1'b0;
    cycles(500);
    rst_n = 1'b0;
    cycles(3);
    expect_buf("t5_rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(300);
    rx = 1'b1;
    cycles(50);
    expect_buf("t5_idle", 8'h00, 1'b0, 1'b0);
    send(8'h55, 1'b1);
    expect_buf("t5", 8'h55, 1'b1, 1'b0);
    rd_pulse();
    send(8'h01, 1'b1);
    expect_buf("t6_first", 8'h01, 1'b1, 1'b0);
    fork
      send(8'h02, 1'b1);
      begin
        cycles(LAT - 1);
        rd_pulse();
      end
    join
    expect_buf("t6", 8'h02, 1'b1, 1'b0);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
